// File: rtl/prog_mem_boot_if.sv
// Fetch and boot-load bus for the writable program memory.
// Groups the fetch request/response signals and the streamed load port.
//   master : fetch stage / external loader side (drives requests and load words)
//   slave  : program memory side (returns instructions and load status)
interface prog_mem_boot_if #(
    parameter int BITS_FOR_INSTRUCTIONS = 5,
    parameter int INSTRUCTION_WIDTH     = 16
);
    // fetch side
    logic                               fetch_req;
    logic [BITS_FOR_INSTRUCTIONS-1:0]   fetch_addr;
    logic [INSTRUCTION_WIDTH-1:0]       instruction;
    logic                               instr_valid;
    logic                               addr_error;
    logic                               fetch_busy;
    // load side
    logic                               load_start;
    logic [BITS_FOR_INSTRUCTIONS-1:0]   load_base;
    logic                               load_valid;
    logic [INSTRUCTION_WIDTH-1:0]       load_data;
    logic                               load_last;
    logic                               load_ready;
    logic                               load_done;
    logic                               load_overflow;
    logic [BITS_FOR_INSTRUCTIONS:0]     load_count;

    modport master (
        output fetch_req, fetch_addr, load_start, load_base,
               load_valid, load_data, load_last,
        input  instruction, instr_valid, addr_error, fetch_busy,
               load_ready, load_done, load_overflow, load_count
    );

    modport slave (
        input  fetch_req, fetch_addr, load_start, load_base,
               load_valid, load_data, load_last,
        output instruction, instr_valid, addr_error, fetch_busy,
               load_ready, load_done, load_overflow, load_count
    );
endinterface

// File: rtl/prog_mem_boot.sv
// Writable program memory with registered 1-cycle fetch and a streamed boot/load port.
// Ports:
//   clk  - single clock, all state updates on the rising edge
//   rst  - synchronous active-high reset (control state only; memory contents survive)
//   bus  - prog_mem_boot_if.slave: fetch request/response plus load stream and status
// Fetches are blocked (instr_valid=0, instruction=NOP_WORD) while a load is running
// and in the cycle a load is started, so read/write collisions cannot occur.
module prog_mem_boot #(
    parameter int                           BITS_FOR_INSTRUCTIONS  = 5,
    parameter int                           INSTRUCTION_WIDTH      = 16,
    parameter int                           NUMBER_OF_INSTRUCTIONS = 32,
    parameter logic [INSTRUCTION_WIDTH-1:0] NOP_WORD               = 16'h000F
) (
    input  logic              clk,
    input  logic              rst,
    prog_mem_boot_if.slave    bus
);
    localparam int AW = BITS_FOR_INSTRUCTIONS;
    localparam int W  = INSTRUCTION_WIDTH;
    localparam logic [AW:0]   DEPTH    = (AW+1)'(NUMBER_OF_INSTRUCTIONS);
    localparam logic [AW-1:0] TOP_ADDR = AW'(NUMBER_OF_INSTRUCTIONS - 1);

    typedef enum logic {IDLE, LOAD} state_t;

    function automatic logic in_range(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH);
    endfunction

    function automatic logic [AW:0] sat_inc(input logic [AW:0] v);
        if (v >= DEPTH) return DEPTH;
        return v + (AW+1)'(1);
    endfunction

    logic [W-1:0] mem [NUMBER_OF_INSTRUCTIONS] = '{default: NOP_WORD};

    state_t        state, state_next;
    logic [AW-1:0] ptr;
    logic [AW:0]   count;
    logic          done, overflow;
    logic          start_ok, start_bad, accept, end_last, end_ovf;

    logic [W-1:0]  instr_p1;
    logic          vld_p1;
    logic          err_p1;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        start_bad  = 1'b0;
        accept     = 1'b0;
        end_last   = 1'b0;
        end_ovf    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.load_start) begin
                    // an out-of-range base never enters LOAD; it just reports overflow
                    if (in_range(bus.load_base)) begin
                        start_ok   = 1'b1;
                        state_next = LOAD;
                    end else begin
                        start_bad  = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (bus.load_valid) begin
                    accept = 1'b1;
                    if (bus.load_last) begin
                        end_last   = 1'b1;
                        state_next = IDLE;
                    end else if (ptr == TOP_ADDR) begin
                        // top address written without load_last: stop, no wrap-around
                        end_ovf    = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            count    <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= start_bad | end_last | end_ovf;
            if (start_ok) begin
                ptr      <= bus.load_base;
                count    <= '0;
                overflow <= 1'b0;
            end else if (start_bad) begin
                overflow <= 1'b1;
            end
            if (accept) begin
                count <= sat_inc(count);
                if (!end_ovf) ptr <= ptr + AW'(1);
            end
            if (end_ovf) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !rst) mem[ptr] <= bus.load_data;
    end

    // ---- stage p1: registered fetch result ----
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_p1 <= NOP_WORD;
            vld_p1   <= 1'b0;
            err_p1   <= 1'b0;
        end else if (bus.fetch_req) begin
            if (state == LOAD || start_ok) begin
                instr_p1 <= NOP_WORD;
                vld_p1   <= 1'b0;
                err_p1   <= 1'b0;
            end else if (!in_range(bus.fetch_addr)) begin
                instr_p1 <= NOP_WORD;
                vld_p1   <= 1'b1;
                err_p1   <= 1'b1;
            end else begin
                instr_p1 <= mem[bus.fetch_addr];
                vld_p1   <= 1'b1;
                err_p1   <= 1'b0;
            end
        end else begin
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
        end
    end

    assign bus.instruction   = instr_p1;
    assign bus.instr_valid   = vld_p1;
    assign bus.addr_error    = err_p1;
    assign bus.fetch_busy    = (state == LOAD);
    assign bus.load_ready    = (state == LOAD);
    assign bus.load_done     = done;
    assign bus.load_overflow = overflow;
    assign bus.load_count    = count;
endmodule

// File: tb/tb_prog_mem_boot.sv
// Testbench for prog_mem_boot: a 32-deep instance (u_a) exercised with directed and
// random loads/fetches against an array model, and a 20-deep instance (u_b) for the
// out-of-range fetch and load-base cases.
module tb_prog_mem_boot;
    localparam logic [15:0] NOP = 16'h000F;

    logic clk;
    logic rst;

    prog_mem_boot_if #(.BITS_FOR_INSTRUCTIONS(5), .INSTRUCTION_WIDTH(16)) ifa ();
    prog_mem_boot_if #(.BITS_FOR_INSTRUCTIONS(5), .INSTRUCTION_WIDTH(16)) ifb ();

    prog_mem_boot #(.BITS_FOR_INSTRUCTIONS(5), .INSTRUCTION_WIDTH(16),
                    .NUMBER_OF_INSTRUCTIONS(32), .NOP_WORD(16'h000F))
        u_a (.clk(clk), .rst(rst), .bus(ifa));

    prog_mem_boot #(.BITS_FOR_INSTRUCTIONS(5), .INSTRUCTION_WIDTH(16),
                    .NUMBER_OF_INSTRUCTIONS(20), .NOP_WORD(16'h000F))
        u_b (.clk(clk), .rst(rst), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] model_a [32];
    logic [15:0] wq [$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fetch_a(input int a);
        ifa.fetch_req  = 1'b1;
        ifa.fetch_addr = a[4:0];
        tick;
        ifa.fetch_req  = 1'b0;
        chk($sformatf("a_vld[%0d]", a), ifa.instr_valid, 1);
        chk($sformatf("a_instr[%0d]", a), ifa.instruction, model_a[a]);
        chk($sformatf("a_err[%0d]", a), ifa.addr_error, 0);
    endtask

    // Streams the words in wq starting at base; the model says where each word lands
    // and when the load should terminate (load_last, or top address reached).
    task automatic do_load(input int base, input bit last_final, input bit hold,
                           input int faddr, output bit ended);
        int cnt;
        bit ovf;
        int addr;
        bit lst;
        cnt   = 0;
        ovf   = 1'b0;
        ended = 1'b0;
        ifa.load_base  = 5'(base);
        ifa.load_start = 1'b1;
        tick;
        ifa.load_start = 1'b0;
        if (hold) begin
            chk("hold_vld_start", ifa.instr_valid, 0);
            chk("hold_nop_start", ifa.instruction, NOP);
        end
        for (int i = 0; i < wq.size(); i++) begin
            addr = base + i;
            if (ended) begin
                chk("ready_after_end", ifa.load_ready, 0);
                ifa.load_valid = 1'b1;
                ifa.load_data  = wq[i];
                ifa.load_last  = 1'b0;
                tick;
                ifa.load_valid = 1'b0;
                continue;
            end
            chk("busy_in_load", ifa.fetch_busy, 1);
            chk("ready_in_load", ifa.load_ready, 1);
            lst = last_final && (i == wq.size() - 1);
            ifa.load_valid = 1'b1;
            ifa.load_data  = wq[i];
            ifa.load_last  = lst;
            tick;
            ifa.load_valid = 1'b0;
            ifa.load_last  = 1'b0;
            model_a[addr] = wq[i];
            cnt++;
            if (hold) begin
                chk("hold_vld", ifa.instr_valid, 0);
                chk("hold_nop", ifa.instruction, NOP);
            end
            if (lst) begin
                ended = 1'b1;
            end else if (addr == 31) begin
                ended = 1'b1;
                ovf   = 1'b1;
            end
            if (ended) begin
                chk("done_pulse", ifa.load_done, 1);
                chk("load_count", ifa.load_count, cnt);
                chk("load_overflow", ifa.load_overflow, ovf);
                chk("busy_after_end", ifa.fetch_busy, 0);
            end else begin
                chk("done_early", ifa.load_done, 0);
            end
        end
        if (ended) begin
            tick;
            chk("done_one_cycle", ifa.load_done, 0);
            if (hold) begin
                chk("hold_first_vld", ifa.instr_valid, 1);
                chk("hold_first_instr", ifa.instruction, model_a[faddr]);
            end
        end
    endtask

    initial begin
        bit ended;
        int base;
        int n;
        int a;

        for (int i = 0; i < 32; i++) model_a[i] = NOP;
        ifa.fetch_req = 0; ifa.fetch_addr = '0; ifa.load_start = 0; ifa.load_base = '0;
        ifa.load_valid = 0; ifa.load_data = '0; ifa.load_last = 0;
        ifb.fetch_req = 0; ifb.fetch_addr = '0; ifb.load_start = 0; ifb.load_base = '0;
        ifb.load_valid = 0; ifb.load_data = '0; ifb.load_last = 0;

        // reset state
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        chk("rst_instr", ifa.instruction, NOP);
        chk("rst_vld", ifa.instr_valid, 0);
        chk("rst_err", ifa.addr_error, 0);
        chk("rst_busy", ifa.fetch_busy, 0);
        chk("rst_ready", ifa.load_ready, 0);
        chk("rst_done", ifa.load_done, 0);
        chk("rst_ovf", ifa.load_overflow, 0);
        chk("rst_count", ifa.load_count, 0);
        chk("rst_b_count", ifb.load_count, 0);
        fetch_a(3);

        // directed load at base 4
        wq = '{16'h1230, 16'h4561, 16'h7892};
        do_load(4, 1'b1, 1'b0, 0, ended);
        fetch_a(4);
        tick;
        chk("hold_instr_no_req", ifa.instruction, 16'h1230);
        chk("no_req_vld", ifa.instr_valid, 0);
        fetch_a(5);
        fetch_a(6);
        fetch_a(7);
        chk("direct_7_nop", ifa.instruction, NOP);

        // fetch held high across a load
        ifa.fetch_req  = 1'b1;
        ifa.fetch_addr = 5'd5;
        wq = '{16'hA5A5, 16'h5A5A};
        do_load(5, 1'b1, 1'b1, 5, ended);
        ifa.fetch_req = 1'b0;
        chk("hold_new_data", ifa.instruction, 16'hA5A5);

        // overflow at the top address
        wq = '{16'hBEE0, 16'hBEE1, 16'hBEE2};
        do_load(30, 1'b0, 1'b0, 0, ended);
        fetch_a(30);
        fetch_a(31);
        fetch_a(0);
        chk("ovf_addr0_nop", ifa.instruction, NOP);

        // reset in the middle of a load
        wq = '{16'hC0C0, 16'hC1C1};
        do_load(10, 1'b0, 1'b0, 0, ended);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("midrst_done", ifa.load_done, 0);
        chk("midrst_busy", ifa.fetch_busy, 0);
        chk("midrst_ready", ifa.load_ready, 0);
        chk("midrst_count", ifa.load_count, 0);
        tick;
        chk("midrst_done2", ifa.load_done, 0);
        fetch_a(10);
        fetch_a(11);
        fetch_a(12);

        // random loads and fetches
        for (int r = 0; r < 6; r++) begin
            wq.delete();
            n = $urandom_range(1, 5);
            for (int k = 0; k < n; k++) wq.push_back(16'($urandom));
            base = $urandom_range(0, 31);
            do_load(base, 1'b1, 1'b0, 0, ended);
            for (int k = 0; k < 4; k++) begin
                a = $urandom_range(0, 31);
                fetch_a(a);
            end
        end

        // 20-deep instance: out-of-range fetch and load base
        ifb.fetch_req  = 1'b1;
        ifb.fetch_addr = 5'd25;
        tick;
        ifb.fetch_req  = 1'b0;
        chk("b_oor_vld", ifb.instr_valid, 1);
        chk("b_oor_err", ifb.addr_error, 1);
        chk("b_oor_instr", ifb.instruction, NOP);
        tick;
        chk("b_idle_err", ifb.addr_error, 0);
        chk("b_idle_vld", ifb.instr_valid, 0);
        ifb.load_base  = 5'd22;
        ifb.load_start = 1'b1;
        tick;
        ifb.load_start = 1'b0;
        chk("b_bad_ovf", ifb.load_overflow, 1);
        chk("b_bad_done", ifb.load_done, 1);
        chk("b_bad_busy", ifb.fetch_busy, 0);
        tick;
        chk("b_bad_done2", ifb.load_done, 0);
        chk("b_ovf_sticky", ifb.load_overflow, 1);
        for (int k = 0; k < 8; k++) begin
            a = $urandom_range(0, 31);
            ifb.fetch_req  = 1'b1;
            ifb.fetch_addr = a[4:0];
            tick;
            ifb.fetch_req  = 1'b0;
            chk($sformatf("b_vld[%0d]", a), ifb.instr_valid, 1);
            chk($sformatf("b_err[%0d]", a), ifb.addr_error, (a >= 20) ? 1 : 0);
            chk($sformatf("b_instr[%0d]", a), ifb.instruction, NOP);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/prog_mem_boot.md
Name: prog_mem_boot

Overview:
- Writable, parametrised successor to the fixed-content program memory.
- Holds the instruction store for the core and serves registered fetches with 1-cycle latency.
- Adds a streamed boot/load port, so programs are loaded at run time instead of being hard-coded at elaboration.
- Sits between the PC/fetch stage and an external loader (testbench or UART bridge).

Parameters:
- BITS_FOR_INSTRUCTIONS, 5: width of the fetch and load addresses.
- INSTRUCTION_WIDTH, 16: instruction word width.
- NUMBER_OF_INSTRUCTIONS, 32: depth. Must be ≤ 2**BITS_FOR_INSTRUCTIONS.
- NOP_WORD, 16'h000F: word returned for blocked or out-of-range fetches, and the elaboration-time content of every entry (low nibble is the NOP opcode 4'b1111).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_req  in  1  fetch request.
- fetch_addr  in  BITS_FOR_INSTRUCTIONS  fetch address.
- instruction  out  INSTRUCTION_WIDTH  registered fetched word.
- instr_valid  out  1  instruction is valid this cycle.
- addr_error  out  1  the fetch just returned was out of range.
- fetch_busy  out  1  a load is in progress and fetches are blocked.
- load_start  in  1  one-cycle pulse that begins a load.
- load_base  in  BITS_FOR_INSTRUCTIONS  first write address, sampled on load_start.
- load_valid  in  1  load word valid.
- load_data  in  INSTRUCTION_WIDTH  load word.
- load_last  in  1  final word of the load; qualified by load_valid.
- load_ready  out  1  block accepts a load word.
- load_done  out  1  one-cycle pulse at the end of a load.
- load_overflow  out  1  sticky flag: load ran past the top address.
- load_count  out  BITS_FOR_INSTRUCTIONS+1  number of words written by the current/last load.

Behaviour:
- Memory array: initialised to NOP_WORD at elaboration. rst does not alter the array contents.
- Reset values: instruction = NOP_WORD; instr_valid, addr_error, fetch_busy, load_ready, load_done, load_overflow = 0; load_count = 0; FSM = IDLE.
- FSM states: IDLE, LOAD.
- IDLE -> LOAD on load_start:
  - write pointer <= load_base; load_count <= 0; load_overflow <= 0.
  - load_start with load_base ≥ NUMBER_OF_INSTRUCTIONS: no state change, load_overflow <= 1, load_done pulses the next cycle.
- In LOAD:
  - load_ready = 1 and fetch_busy = 1.
  - A word is accepted when load_valid & load_ready. On acceptance: mem[ptr] <= load_data, ptr++, load_count++.
- LOAD -> IDLE happens on any of these:
  - accepted word with load_last = 1;
  - accepted word written at address NUMBER_OF_INSTRUCTIONS-1 with load_last = 0: also sets load_overflow; no wrap-around and no further writes;
  - rst.
- load_done pulses for 1 cycle in the cycle after the LOAD -> IDLE transition. There is no load_done on reset.
- load_start while in LOAD is ignored.
- rst mid-load: words already written stay in memory; FSM returns to IDLE.
- Fetch in IDLE, request in cycle N, result in cycle N+1:
  - instr_valid = 1.
  - In range: instruction = mem[fetch_addr].
  - fetch_addr ≥ NUMBER_OF_INSTRUCTIONS: instruction = NOP_WORD and addr_error = 1.
- No fetch_req: instr_valid = 0, addr_error = 0, instruction holds its previous value.
- Fetch during LOAD, or in the same cycle as a load_start accepted from IDLE:
  - not serviced; next cycle gives instr_valid = 0 and instruction = NOP_WORD;
  - the requester must retry.
- Read/write collision on the same address cannot occur, because fetches are blocked in LOAD.
- load_count saturates at NUMBER_OF_INSTRUCTIONS.

Test Plan:
- Reset then check: all outputs at their reset values; fetch_req with addr 3 gives instruction = 16'h000F, instr_valid = 1 one cycle later.
- load_start with base 4, then words 16'h1230, 16'h4561, 16'h7892 (last): load_done pulses, load_count = 3. Fetches of addrs 4/5/6 return those words at 1-cycle latency; addr 7 returns 16'h000F.
- Load with base 30 and 3 words, last = 0 throughout: addrs 30 and 31 are written, the third word is not accepted, load_overflow = 1, addr 0 unchanged.
- fetch_req held high during a load: instr_valid = 0 and fetch_busy = 1 throughout; the first fetch after load_done returns the new data.
- With NUMBER_OF_INSTRUCTIONS = 20: fetch addr 25 gives addr_error = 1 and instruction = NOP_WORD; load_start with base 22 sets load_overflow and pulses load_done.
- Assert rst after 2 of 4 words: FSM returns to IDLE, no load_done; fetches return the 2 written words and the old contents elsewhere.
